// File: rtl/hit_test_pulse_gen.sv
// Synthetic hit-pulse source for ground test: programmable width, ch9 delay, period and burst.
// Output pulses are registered and fed ahead of the hit/trigger counters in test mode.
module hit_test_pulse_gen #(
    parameter int unsigned NCH     = 13,
    parameter int unsigned MIN_GAP = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            start_in,
    input  logic            stop_in,
    input  logic [NCH-1:0]  chan_mask_in,
    input  logic [3:0]      width_in,
    input  logic [7:0]      delay_in,
    input  logic [15:0]     period_in,
    input  logic [15:0]     burst_in,
    output logic [NCH-1:0]  hit_test_out,
    output logic            gen_busy_out,
    output logic            done_out,
    output logic [15:0]     sent_cnt_out
);

    localparam int unsigned DelayCh = 9;

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e         state_q, state_d;
    logic [15:0]    ec_q, ec_d;
    logic [15:0]    sent_q, sent_d;
    logic           stop_pend_q, stop_pend_d;
    logic [NCH-1:0] hit_q, hit_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           latch;

    logic [NCH-1:0] mask_q;
    logic [3:0]     width_q;
    logic [7:0]     delay_q;
    logic [15:0]    period_q;
    logic [15:0]    burst_q;

    logic [3:0]     width_eff;
    logic [16:0]    min_period;
    logic [16:0]    period_17;
    logic [15:0]    period_eff;
    logic           last_ec;
    logic           in_width;
    logic           in_delay;

    // Period is stretched so that ch9's delayed pulse still leaves MIN_GAP low cycles.
    always_comb begin
        width_eff  = (width_in == 4'd0) ? 4'd1 : width_in;
        min_period = {9'd0, delay_in} + {13'd0, width_eff} + 17'(MIN_GAP);
        period_17  = ({1'b0, period_in} > min_period) ? {1'b0, period_in} : min_period;
        period_eff = period_17[16] ? 16'hFFFF : period_17[15:0];
    end

    always_comb begin
        last_ec  = (ec_q == period_q - 16'd1);
        in_width = ({1'b0, ec_q} < {13'd0, width_q});
        in_delay = ({1'b0, ec_q} >= {9'd0, delay_q}) &&
                   ({1'b0, ec_q} < ({9'd0, delay_q} + {13'd0, width_q}));
    end

    always_comb begin
        state_d     = state_q;
        ec_d        = ec_q;
        sent_d      = sent_q;
        stop_pend_d = stop_pend_q;
        hit_d       = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        latch       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_in && !stop_in) begin
                    state_d     = StRun;
                    ec_d        = 16'd0;
                    sent_d      = 16'd1;
                    stop_pend_d = 1'b0;
                    busy_d      = 1'b1;
                    latch       = 1'b1;
                end else if (done_q) begin
                    busy_d = 1'b0;
                end
            end
            StRun: begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    hit_d[i] = mask_q[i] && ((i == DelayCh) ? in_delay : in_width);
                end
                if (stop_in) stop_pend_d = 1'b1;
                if (last_ec) begin
                    if (stop_pend_q || stop_in || (burst_q != 16'd0 && sent_q == burst_q)) begin
                        state_d = StFinish;
                    end else begin
                        ec_d   = 16'd0;
                        sent_d = sent_q + 16'd1;
                    end
                end else begin
                    ec_d = ec_q + 16'd1;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            ec_q        <= '0;
            sent_q      <= '0;
            stop_pend_q <= 1'b0;
            hit_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mask_q      <= '0;
            width_q     <= '0;
            delay_q     <= '0;
            period_q    <= '0;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            ec_q        <= ec_d;
            sent_q      <= sent_d;
            stop_pend_q <= stop_pend_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            if (latch) begin
                mask_q   <= chan_mask_in;
                width_q  <= width_eff;
                delay_q  <= delay_in;
                period_q <= period_eff;
                burst_q  <= burst_in;
            end
        end
    end

    assign hit_test_out = hit_q;
    assign gen_busy_out = busy_q;
    assign done_out     = done_q;
    assign sent_cnt_out = sent_q;

endmodule
